// File: rtl/kmap_sweep_checker.sv
// Truth-table sweeper: drives 0..2^NVARS-1 into a combinational function, checks against a minterm mask.
// Optional KMAP_SETTLE_EN inserts a register stage on the FUT output (2 cycles per minterm).
module kmap_sweep_checker #(
  parameter  int NVARS  = 4,
  localparam int MASK_W = 1 << NVARS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MASK_W-1:0] minterm_mask,
  output logic [NVARS-1:0]  dut_in,
  input  logic              dut_f,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [NVARS:0]    err_count,
  output logic [NVARS-1:0]  first_err,
  output logic              first_err_valid,
  output logic [MASK_W-1:0] captured
);

`ifdef KMAP_SETTLE_EN
  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_SETTLE, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;
`endif

  state_t              state_q, state_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic [NVARS-1:0]    dut_in_q, dut_in_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [NVARS:0]      err_count_q, err_count_d;
  logic [NVARS-1:0]    first_err_q, first_err_d;
  logic                first_err_valid_q, first_err_valid_d;
  logic [MASK_W-1:0]   captured_q, captured_d;
`ifdef KMAP_SETTLE_EN
  logic                fut_q, fut_d;
`endif

  logic                do_cmp;
  logic                cmp_f;

  always_comb begin
    state_d           = state_q;
    mask_d            = mask_q;
    dut_in_d          = dut_in_q;
    busy_d            = busy_q;
    done_d            = 1'b0;
    pass_d            = pass_q;
    err_count_d       = err_count_q;
    first_err_d       = first_err_q;
    first_err_valid_d = first_err_valid_q;
    captured_d        = captured_q;
    do_cmp            = 1'b0;
`ifdef KMAP_SETTLE_EN
    fut_d             = fut_q;
    cmp_f             = fut_q;
`else
    cmp_f             = dut_f;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d            = minterm_mask;
          err_count_d       = '0;
          first_err_d       = '0;
          first_err_valid_d = 1'b0;
          captured_d        = '0;
          pass_d            = 1'b0;
          dut_in_d          = '0;
          busy_d            = 1'b1;
          state_d           = S_SWEEP;
        end
      end
      S_SWEEP: begin
`ifdef KMAP_SETTLE_EN
        // Register the FUT output here; the compare happens from the register in SETTLE.
        fut_d   = dut_f;
        state_d = S_SETTLE;
`else
        do_cmp  = 1'b1;
`endif
      end
`ifdef KMAP_SETTLE_EN
      S_SETTLE: begin
        do_cmp = 1'b1;
      end
`endif
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_count_q == '0);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (do_cmp) begin
      captured_d[dut_in_q] = cmp_f;
      if (cmp_f != mask_q[dut_in_q]) begin
        err_count_d = err_count_q + (NVARS+1)'(1);
        if (!first_err_valid_q) begin
          first_err_d       = dut_in_q;
          first_err_valid_d = 1'b1;
        end
      end
      // Last minterm: leave dut_in parked rather than wrapping to 0.
      if (dut_in_q == {NVARS{1'b1}}) begin
        state_d = S_DONE;
      end else begin
        dut_in_d = dut_in_q + NVARS'(1);
        state_d  = S_SWEEP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= S_IDLE;
      mask_q            <= '0;
      dut_in_q          <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
      err_count_q       <= '0;
      first_err_q       <= '0;
      first_err_valid_q <= 1'b0;
      captured_q        <= '0;
`ifdef KMAP_SETTLE_EN
      fut_q             <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      mask_q            <= mask_d;
      dut_in_q          <= dut_in_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      pass_q            <= pass_d;
      err_count_q       <= err_count_d;
      first_err_q       <= first_err_d;
      first_err_valid_q <= first_err_valid_d;
      captured_q        <= captured_d;
`ifdef KMAP_SETTLE_EN
      fut_q             <= fut_d;
`endif
    end
  end

  assign dut_in          = dut_in_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_count_q;
  assign first_err       = first_err_q;
  assign first_err_valid = first_err_valid_q;
  assign captured        = captured_q;

endmodule

// File: tb/tb_kmap_sweep_checker.sv
// Bench for kmap_sweep_checker: NVARS=4/3/2 instances with table-modelled FUTs.
module tb_kmap_sweep_checker;

`ifdef KMAP_SETTLE_EN
  localparam int LAT4 = 33;
`else
  localparam int LAT4 = 17;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // NVARS=4 instance
  logic [15:0] mask4, fut4;
  logic [3:0]  dut_in4, first_err4;
  logic        dut_f4, busy4, done4, pass4, fv4;
  logic [4:0]  err4;
  logic [15:0] cap4;
  assign dut_f4 = fut4[dut_in4];

  kmap_sweep_checker #(.NVARS(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .minterm_mask(mask4),
    .dut_in(dut_in4), .dut_f(dut_f4), .busy(busy4), .done(done4),
    .pass(pass4), .err_count(err4), .first_err(first_err4),
    .first_err_valid(fv4), .captured(cap4));

  // NVARS=3 instance
  logic [7:0] mask3, fut3, cap3;
  logic [2:0] dut_in3, first_err3;
  logic       dut_f3, busy3, done3, pass3, fv3;
  logic [3:0] err3;
  assign dut_f3 = fut3[dut_in3];

  kmap_sweep_checker #(.NVARS(3)) u3 (
    .clk(clk), .rst(rst), .start(start), .minterm_mask(mask3),
    .dut_in(dut_in3), .dut_f(dut_f3), .busy(busy3), .done(done3),
    .pass(pass3), .err_count(err3), .first_err(first_err3),
    .first_err_valid(fv3), .captured(cap3));

  // NVARS=2 instance
  logic [3:0] mask2, fut2, cap2;
  logic [1:0] dut_in2, first_err2;
  logic       dut_f2, busy2, done2, pass2, fv2;
  logic [2:0] err2;
  assign dut_f2 = fut2[dut_in2];

  kmap_sweep_checker #(.NVARS(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .minterm_mask(mask2),
    .dut_in(dut_in2), .dut_f(dut_f2), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(err2), .first_err(first_err2),
    .first_err_valid(fv2), .captured(cap2));

  typedef struct {
    logic [15:0] fut;
    logic [15:0] mask;
    logic        exp_pass;
    logic [4:0]  exp_err;
    logic [3:0]  exp_fe;
    logic        exp_fv;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Start a sweep on the next edge and return edges from start-sample to done.
  task automatic run4(output int lat);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy4}, 32'd1);
    lat = 0;
    while (!done4 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input vec_t v);
    chk({tag, "_pass"}, {31'd0, pass4}, {31'd0, v.exp_pass});
    chk({tag, "_err"}, {27'd0, err4}, {27'd0, v.exp_err});
    chk({tag, "_fv"}, {31'd0, fv4}, {31'd0, v.exp_fv});
    if (v.exp_fv) chk({tag, "_fe"}, {28'd0, first_err4}, {28'd0, v.exp_fe});
    chk({tag, "_cap"}, {16'd0, cap4}, {16'd0, v.fut});
    chk({tag, "_busy_at_done"}, {31'd0, busy4}, 32'd0);
  endtask

  initial begin
    int lat;
    int cyc;
    bit pulsed;

    vecs[0] = '{16'hA5A5, 16'hA5A5, 1'b1, 5'd0,  4'd0,  1'b0};
    vecs[1] = '{16'hA5A5, 16'hA5A4, 1'b0, 5'd1,  4'd0,  1'b1};
    vecs[2] = '{16'hA5A5, 16'h0000, 1'b0, 5'd8,  4'd0,  1'b1};
    vecs[3] = '{16'hA5A5, 16'hFFFF, 1'b0, 5'd8,  4'd1,  1'b1};
    vecs[4] = '{16'hA5A5, 16'h5A5A, 1'b0, 5'd16, 4'd0,  1'b1};
    vecs[5] = '{16'h8000, 16'h0000, 1'b0, 5'd1,  4'd15, 1'b1};

    fut4 = 16'hA5A5; mask4 = 16'hA5A5;
    fut3 = 8'hA6;    mask3 = 8'hA6;
    fut2 = 4'h6;     mask2 = 4'h6;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy4}, 32'd0);
    chk("rst_done", {31'd0, done4}, 32'd0);
    chk("rst_pass", {31'd0, pass4}, 32'd0);
    chk("rst_err", {27'd0, err4}, 32'd0);
    chk("rst_dut_in", {28'd0, dut_in4}, 32'd0);
    chk("rst_cap", {16'd0, cap4}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      fut4  = vecs[i].fut;
      mask4 = vecs[i].mask;
      run4(lat);
      chk($sformatf("v%0d_lat", i), lat, LAT4);
      check_result($sformatf("v%0d", i), vecs[i]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), {31'd0, done4}, 32'd0);
      if (i == 0) begin
        chk("n3_pass", {31'd0, pass3}, 32'd1);
        chk("n3_cap", {24'd0, cap3}, 32'h0000_00A6);
        chk("n3_err", {28'd0, err3}, 32'd0);
        chk("n2_pass", {31'd0, pass2}, 32'd1);
        chk("n2_cap", {28'd0, cap2}, 32'h0000_0006);
      end
    end

    // Results hold in IDLE until the next start.
    repeat (3) @(posedge clk);
    #1;
    chk("hold_err", {27'd0, err4}, 32'd1);
    chk("hold_fe", {28'd0, first_err4}, 32'd15);

    // Reset mid-sweep at dut_in=5.
    fut4 = 16'hA5A5; mask4 = 16'hA5A4;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (dut_in4 != 4'd5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_idx5", {28'd0, dut_in4}, 32'd5);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy4}, 32'd0);
    chk("midrst_done", {31'd0, done4}, 32'd0);
    chk("midrst_dut_in", {28'd0, dut_in4}, 32'd0);
    chk("midrst_cap", {16'd0, cap4}, 32'd0);
    chk("midrst_err", {27'd0, err4}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mask4 = 16'hA5A5;
    run4(lat);
    chk("postrst_lat", lat, LAT4);
    check_result("postrst", vecs[0]);

    // Stray start at idx 3 and mask change at idx 7 during a sweep.
    fut4 = 16'hA5A5; mask4 = 16'hA5A5;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    pulsed = 1'b0;
    while (!done4 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      start = 1'b0;
      if (dut_in4 == 4'd3 && !pulsed) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      if (dut_in4 == 4'd7) mask4 = 16'h0000;
    end
    start = 1'b0;
    chk("ignore_lat", lat, LAT4);
    check_result("ignore", vecs[0]);
    repeat (3) @(posedge clk);
    #1;
    chk("ignore_no_resweep", {31'd0, busy4}, 32'd0);
    mask4 = 16'hA5A5;

    // Start held high: one sweep every LAT4+1 edges.
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    while (!done4 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("held_first_done", {31'd0, done4}, 32'd1);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!done4 && cyc < 200);
    start = 1'b0;
    chk("held_period", cyc, LAT4 + 1);
    chk("held_pass", {31'd0, pass4}, 32'd1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
